// File: rtl/inst_queue.sv
// inst_queue: four-entry instruction buffer between fetch and decode.
// Holds {adel, pc, instr} triples in a circular array, presents the oldest
// one to decode, absorbs decode stalls, drops everything on flush and
// tracks whether the head instruction sits in a branch delay slot.
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              fetch_valid,
   input  logic [31:0]       fetch_pc,
   input  logic [31:0]       fetch_instr,
   input  logic              fetch_adel,
   output logic              fetch_ready,
   input  logic              stallD,
   output logic              validD,
   output logic [31:0]       instrD,
   output logic [31:0]       pcD,
   output logic              adelD,
   output logic              is_in_delayslotD,
   output logic [PTR_W:0]    countD
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [31:0]      pcMem    [DEPTH];
   logic [31:0]      instrMem [DEPTH];
   logic             adelMem  [DEPTH];

   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic [PTR_W:0]   count;
   logic             dsPending;

   logic             push;
   logic             pop;
   logic [5:0]       headOp;
   logic [5:0]       headFunct;
   logic             headBranch;

   // Handshake and occupancy status; ready depends only on the registered count
   assign fetch_ready = (count != FULL_COUNT);
   assign validD      = (count != '0);
   assign push        = fetch_valid & fetch_ready & ~flush;
   assign pop         = validD & ~stallD & ~flush;

   // Head entry presented to decode, forced to a nop image when empty
   assign instrD           = validD ? instrMem[rp] : 32'h0;
   assign pcD              = validD ? pcMem[rp]    : 32'h0;
   assign adelD            = validD & adelMem[rp];
   assign is_in_delayslotD = validD & dsPending;
   assign countD           = count;

   assign headOp    = instrD[31:26];
   assign headFunct = instrD[5:0];

   // Classify the head instruction as a control transfer that owns a delay slot
   always_comb begin
      headBranch = 1'b0;
      casez (headOp)
         6'b000001: headBranch = 1'b1;
         6'b00001?: headBranch = 1'b1;
         6'b0001??: headBranch = 1'b1;
         6'b000000: headBranch = (headFunct[5:1] == 5'b00100);
         default:   headBranch = 1'b0;
      endcase
   end

   // Entry storage; written only on an accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wp]    <= fetch_pc;
         instrMem[wp] <= fetch_instr;
         adelMem[wp]  <= fetch_adel;
      end
   end

   // Pointers and occupancy; flush behaves exactly like reset for these
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Remember whether the instruction just handed to decode was a branch
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         dsPending <= 1'b0;
      end else if (pop) begin
         dsPending <= headBranch;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenarios plus a randomized run of inst_queue,
// each compared against a queue-based reference model of the buffer.
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } entry_t;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              fetch_valid;
   logic [31:0]       fetch_pc;
   logic [31:0]       fetch_instr;
   logic              fetch_adel;
   logic              fetch_ready;
   logic              stallD;
   logic              validD;
   logic [31:0]       instrD;
   logic [31:0]       pcD;
   logic              adelD;
   logic              is_in_delayslotD;
   logic [PTR_W:0]    countD;

   int checks = 0;
   int errors = 0;

   // Reference model state
   entry_t      mq[$];
   bit          mDs;
   bit          mPopped;
   logic [31:0] mPoppedPc;

   inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .fetch_valid      (fetch_valid),
      .fetch_pc         (fetch_pc),
      .fetch_instr      (fetch_instr),
      .fetch_adel       (fetch_adel),
      .fetch_ready      (fetch_ready),
      .stallD           (stallD),
      .validD           (validD),
      .instrD           (instrD),
      .pcD              (pcD),
      .adelD            (adelD),
      .is_in_delayslotD (is_in_delayslotD),
      .countD           (countD)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit isBranchRef(logic [31:0] ins);
      int op;
      int fn;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      return (op == 1) || (op == 2) || (op == 3) || (op >= 4 && op <= 7) ||
             (op == 0 && (fn == 8 || fn == 9));
   endfunction

   function automatic bit expValid();
      return mq.size() != 0;
   endfunction

   function automatic logic [31:0] expPc();
      return (mq.size() != 0) ? mq[0].pc : 32'h0;
   endfunction

   function automatic logic [31:0] expInstr();
      return (mq.size() != 0) ? mq[0].instr : 32'h0;
   endfunction

   function automatic logic expAdel();
      return (mq.size() != 0) ? mq[0].adel : 1'b0;
   endfunction

   function automatic logic expDs();
      return (mq.size() != 0) && mDs;
   endfunction

   function automatic logic [PTR_W:0] expCount();
      return (PTR_W + 1)'(mq.size());
   endfunction

   function automatic logic expReady();
      return mq.size() != DEPTH;
   endfunction

   task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                                input logic [31:0] ins, input logic ad,
                                input logic st, input logic fl);
      fetch_valid = fv;
      fetch_pc    = pc;
      fetch_instr = ins;
      fetch_adel  = ad;
      stallD      = st;
      flush       = fl;
   endtask

   // Advance one clock: the model consumes the same inputs the DUT sees
   task automatic cycle();
      bit doPush;
      bit doPop;
      entry_t e;
      @(posedge clk);
      mPopped = 1'b0;
      if (rst || flush) begin
         mq.delete();
         mDs = 1'b0;
      end else begin
         doPush = fetch_valid && (mq.size() != DEPTH);
         doPop  = (mq.size() != 0) && !stallD;
         if (doPop) begin
            mDs       = isBranchRef(mq[0].instr);
            mPoppedPc = mq[0].pc;
            mPopped   = 1'b1;
            void'(mq.pop_front());
         end
         if (doPush) begin
            e.pc    = fetch_pc;
            e.instr = fetch_instr;
            e.adel  = fetch_adel;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      cycle();
      rst = 1'b0;
      checks++;
      if (validD !== 1'b0) begin errors++; $display("[TB] FAIL reset_validD: got %b expected 0", validD); end
      checks++;
      if (instrD !== 32'h0) begin errors++; $display("[TB] FAIL reset_instrD: got %h expected 0", instrD); end
      checks++;
      if (pcD !== 32'h0) begin errors++; $display("[TB] FAIL reset_pcD: got %h expected 0", pcD); end
      checks++;
      if (adelD !== 1'b0 || is_in_delayslotD !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got adel=%b ds=%b expected 0 0", adelD, is_in_delayslotD);
      end
      checks++;
      if (countD !== '0) begin errors++; $display("[TB] FAIL reset_countD: got %0d expected 0", countD); end
      checks++;
      if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", fetch_ready); end
   endtask

   task automatic test_stream();
      logic [31:0] pcs [3];
      pcs[0] = 32'hBFC0_0000;
      pcs[1] = 32'hBFC0_0004;
      pcs[2] = 32'hBFC0_0008;
      applyStimulus(1'b1, pcs[0], 32'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (validD !== 1'b0) begin errors++; $display("[TB] FAIL stream_no_bypass: got %b expected 0", validD); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, pcs[i], 32'h2400_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
         cycle();
         checks++;
         if (validD !== 1'b1 || pcD !== pcs[i]) begin
            errors++; $display("[TB] FAIL stream_head: got valid=%b pc=%h expected 1 %h", validD, pcD, pcs[i]);
         end
         checks++;
         if (countD !== 3'd1) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 1", countD); end
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++;
      if (validD !== 1'b0 || countD !== '0) begin
         errors++; $display("[TB] FAIL stream_drain: got valid=%b count=%0d expected 0 0", validD, countD);
      end
   endtask

   task automatic test_fill_stall();
      logic [31:0] nextPc;
      bit accepted;
      nextPc = 32'h100;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, nextPc, 32'h0, 1'b0, 1'b1, 1'b0);
         accepted = expReady();
         cycle();
         if (accepted) nextPc = nextPc + 32'd4;
      end
      checks++;
      if (countD !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", countD); end
      checks++;
      if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready: got %b expected 0", fetch_ready); end
      checks++;
      if (pcD !== 32'h100) begin errors++; $display("[TB] FAIL fill_head_stable: got %h expected 00000100", pcD); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (pcD !== 32'h100 + 32'(4 * i)) begin
            errors++; $display("[TB] FAIL drain_order: got %h expected %h", pcD, 32'h100 + 32'(4 * i));
         end
         checks++;
         if (fetch_ready !== (i != 0)) begin
            errors++; $display("[TB] FAIL drain_ready: got %b expected %b", fetch_ready, (i != 0));
         end
         cycle();
      end
      checks++;
      if (validD !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", validD); end
   endtask

   task automatic test_wrap_around();
      logic [31:0] nextPc;
      int popCount;
      int cyc;
      bit accepted;
      nextPc   = 32'h300;
      popCount = 0;
      cyc      = 0;
      while (popCount < 10 && cyc < 100) begin
         applyStimulus(nextPc < 32'h300 + 32'd40, nextPc, 32'h0, 1'b0, ((cyc / 2) % 2) == 1, 1'b0);
         accepted = fetch_valid && expReady();
         checks++;
         if (validD !== expValid() || pcD !== expPc()) begin
            errors++; $display("[TB] FAIL wrap_head: got valid=%b pc=%h expected %b %h", validD, pcD, expValid(), expPc());
         end
         cycle();
         if (accepted) nextPc = nextPc + 32'd4;
         if (mPopped) begin
            checks++;
            if (mPoppedPc !== 32'h300 + 32'(4 * popCount)) begin
               errors++; $display("[TB] FAIL wrap_seq: got %h expected %h", mPoppedPc, 32'h300 + 32'(4 * popCount));
            end
            popCount++;
         end
         cyc++;
      end
      checks++;
      if (popCount != 10) begin errors++; $display("[TB] FAIL wrap_budget: got %0d pops expected 10", popCount); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'h1111_0000, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      checks++;
      if (countD !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", countD); end
      applyStimulus(1'b1, 32'h40C, 32'h2222_0000, 1'b0, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (countD !== '0 || validD !== 1'b0 || instrD !== 32'h0) begin
         errors++; $display("[TB] FAIL flush_clear: got count=%0d valid=%b instr=%h expected 0 0 0", countD, validD, instrD);
      end
      cycle();
      checks++;
      if (validD !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop: got %b expected 0", validD); end
   endtask

   task automatic test_delay_slot(input logic [31:0] brInstr, input logic [31:0] basePc);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, basePc + 32'(4 * i), (i == 0) ? brInstr : 32'h0, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      checks++;
      if (is_in_delayslotD !== 1'b0) begin errors++; $display("[TB] FAIL ds_before: got %b expected 0", is_in_delayslotD); end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++;
      if (is_in_delayslotD !== 1'b1 || pcD !== basePc + 32'd4) begin
         errors++; $display("[TB] FAIL ds_slot: got ds=%b pc=%h expected 1 %h", is_in_delayslotD, pcD, basePc + 32'd4);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      cycle();
      checks++;
      if (is_in_delayslotD !== 1'b1) begin errors++; $display("[TB] FAIL ds_stall_hold: got %b expected 1", is_in_delayslotD); end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++;
      if (is_in_delayslotD !== 1'b0 || pcD !== basePc + 32'd8) begin
         errors++; $display("[TB] FAIL ds_after: got ds=%b pc=%h expected 0 %h", is_in_delayslotD, pcD, basePc + 32'd8);
      end
      cycle();
   endtask

   task automatic test_adel();
      applyStimulus(1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle();
      applyStimulus(1'b1, 32'h0000_0106, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      checks++;
      if (adelD !== 1'b1 || pcD !== 32'h102) begin
         errors++; $display("[TB] FAIL adel_head: got adel=%b pc=%h expected 1 00000102", adelD, pcD);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++;
      if (adelD !== 1'b0 || pcD !== 32'h106) begin
         errors++; $display("[TB] FAIL adel_next: got adel=%b pc=%h expected 0 00000106", adelD, pcD);
      end
      cycle();
   endtask

   task automatic test_random();
      logic [31:0] ins;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: ins = 32'h1022_0003;
            1: ins = 32'h03E0_0008;
            2: ins = 32'h0800_0000 | ($urandom & 32'h03FF_FFFF);
            3: ins = 32'h0401_0000 | ($urandom & 32'h0000_FFFF);
            4: ins = ($urandom & 32'h03FF_FFC0) | 32'h9;
            default: ins = $urandom;
         endcase
         rst = ($urandom_range(0, 63) == 0);
         applyStimulus($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, ins,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 15) == 0);
         cycle();
         checks++;
         if (validD !== expValid() || pcD !== expPc() || instrD !== expInstr()) begin
            errors++; $display("[TB] FAIL rand_head: got %b %h %h expected %b %h %h",
                               validD, pcD, instrD, expValid(), expPc(), expInstr());
         end
         checks++;
         if (adelD !== expAdel() || is_in_delayslotD !== expDs()) begin
            errors++; $display("[TB] FAIL rand_flags: got adel=%b ds=%b expected %b %b",
                               adelD, is_in_delayslotD, expAdel(), expDs());
         end
         checks++;
         if (countD !== expCount() || fetch_ready !== expReady()) begin
            errors++; $display("[TB] FAIL rand_count: got count=%0d ready=%b expected %0d %b",
                               countD, fetch_ready, expCount(), expReady());
         end
      end
      rst = 1'b0;
   endtask

   // Scenario sequence
   initial begin
      mDs       = 1'b0;
      mPopped   = 1'b0;
      mPoppedPc = 32'h0;
      rst       = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_stream();
      test_fill_stall();
      test_wrap_around();
      test_flush();
      test_delay_slot(32'h1022_0003, 32'h200);
      test_delay_slot(32'h03E0_0008, 32'h500);
      test_adel();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
